// File: rtl/idt_serial_prog.sv
// Serial programmer for ICS307-class clock synthesizers: shifts a configuration
// word out on sclk/data, pulses the load strobe, then waits a settle interval before asserting lock.
module idt_serial_prog #(
  parameter int unsigned      CFG_W         = 24,
  parameter logic [CFG_W-1:0] DEFAULT_CFG   = 24'h36A7EB,
  parameter bit               AUTO_START    = 1'b1,
  parameter bit               LSB_FIRST     = 1'b0,
  parameter int unsigned      SCLK_HALF     = 1,
  parameter int unsigned      STROBE_CYCLES = 2,
  parameter int unsigned      SETTLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             idt_iclk,
  output logic             idt_sclk,
  output logic             idt_data,
  output logic             idt_strobe,
  output logic             busy,
  output logic             locked,
  output logic             done
);

  localparam int unsigned PH_W  = $clog2(2 * SCLK_HALF + 1);
  localparam int unsigned BIT_W = $clog2(CFG_W);
  localparam int unsigned STB_W = $clog2(STROBE_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(SCLK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_MAX  = '1;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STROBE = 3'd3,
    ST_SETTLE = 3'd4,
    ST_LOCKED = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   sreg_q, sreg_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic               sclk_q, sclk_d, data_q, data_d, strobe_q, strobe_d;
  logic               busy_q, busy_d, locked_q, locked_d, done_q, done_d, ready_q, ready_d;
  logic               start_s;
  logic [CFG_W-1:0]   word_s;
  logic [CFG_W-1:0]   next_sreg_s;

  function automatic logic first_bit(input logic [CFG_W-1:0] w);
    return LSB_FIRST ? w[0] : w[CFG_W-1];
  endfunction

  function automatic logic [CFG_W-1:0] advance(input logic [CFG_W-1:0] w);
    return LSB_FIRST ? {1'b0, w[CFG_W-1:1]} : {w[CFG_W-2:0], 1'b0};
  endfunction

  assign idt_iclk = clk;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    stb_cnt_d   = stb_cnt_q;
    set_cnt_d   = set_cnt_q;
    sclk_d      = sclk_q;
    data_d      = data_q;
    strobe_d    = strobe_q;
    busy_d      = busy_q;
    locked_d    = locked_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    start_s     = 1'b0;
    word_s      = '0;
    next_sreg_s = advance(sreg_q);

    case (state_q)
      ST_START: begin
        if (AUTO_START) begin
          start_s = 1'b1;
          word_s  = DEFAULT_CFG;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE, ST_LOCKED: begin
        if (cfg_valid && ready_q) begin
          start_s = 1'b1;
          word_s  = cfg_data;
        end else begin
          start_s = 1'b0;
        end
      end
      // Each bit: data changes on entry to the low phase, sclk rises after SCLK_HALF cycles.
      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d   = ST_STROBE;
            bit_d     = '0;
            data_d    = 1'b0;
            strobe_d  = 1'b1;
            stb_cnt_d = '0;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sreg_d = next_sreg_s;
            data_d = first_bit(next_sreg_s);
          end
        end else begin
          ph_d   = ph_q + PH_W'(1);
          sclk_d = ((ph_q + PH_W'(1)) >= PH_HIGH);
        end
      end
      ST_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          state_d   = ST_SETTLE;
          strobe_d  = 1'b0;
          set_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end else if (set_cnt_q != SET_MAX) begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end else begin
          set_cnt_d = set_cnt_q;
        end
      end
      default: begin
        state_d  = ST_START;
        sclk_d   = 1'b0;
        data_d   = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
        locked_d = 1'b0;
        ready_d  = 1'b0;
      end
    endcase

    // Common entry into SHIFT from START, IDLE or LOCKED; first bit is presented immediately.
    if (start_s) begin
      state_d  = ST_SHIFT;
      sreg_d   = word_s;
      data_d   = first_bit(word_s);
      sclk_d   = 1'b0;
      ph_d     = '0;
      bit_d    = '0;
      busy_d   = 1'b1;
      locked_d = 1'b0;
      ready_d  = 1'b0;
    end else begin
      start_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_START;
      sreg_q    <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      stb_cnt_q <= '0;
      set_cnt_q <= '0;
      sclk_q    <= 1'b0;
      data_q    <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      stb_cnt_q <= stb_cnt_d;
      set_cnt_q <= set_cnt_d;
      sclk_q    <= sclk_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign idt_sclk   = sclk_q;
  assign idt_data   = data_q;
  assign idt_strobe = strobe_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign done       = done_q;

endmodule

// File: tb/tb_idt_serial_prog.sv
// Directed bench for idt_serial_prog: a default-parameter instance (a) and a
// 16-bit, LSB-first, slow-sclk, request-driven instance (b).
module tb_idt_serial_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ready_a, iclk_a, sclk_a, data_a, strobe_a, busy_a, locked_a, done_a;
  logic [23:0] cfg_a;
  logic        rst_b, valid_b, ready_b, iclk_b, sclk_b, data_b, strobe_b, busy_b, locked_b, done_b;
  logic [15:0] cfg_b;

  idt_serial_prog #(.SETTLE_CYCLES(20)) u_a (
    .clk(clk), .rst_n(rst_a), .cfg_data(cfg_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .idt_iclk(iclk_a), .idt_sclk(sclk_a), .idt_data(data_a), .idt_strobe(strobe_a),
    .busy(busy_a), .locked(locked_a), .done(done_a)
  );

  idt_serial_prog #(
    .CFG_W(16), .DEFAULT_CFG(16'h0000), .AUTO_START(1'b0), .LSB_FIRST(1'b1),
    .SCLK_HALF(3), .STROBE_CYCLES(2), .SETTLE_CYCLES(10)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .cfg_data(cfg_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .idt_iclk(iclk_b), .idt_sclk(sclk_b), .idt_data(data_b), .idt_strobe(strobe_b),
    .busy(busy_b), .locked(locked_b), .done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Serial capture for instance a: MSB-first, keeps the last 24 bits seen on sclk rises.
  logic [23:0] a_word = '0;
  int          a_bits = 0;
  int          a_stb  = 0;
  logic        a_psclk = 1'b0, a_pstb = 1'b0;
  always @(negedge clk) begin
    if (sclk_a && !a_psclk) begin
      a_word = {a_word[22:0], data_a};
      a_bits++;
    end
    if (strobe_a && !a_pstb) a_stb++;
    a_psclk = sclk_a;
    a_pstb  = strobe_a;
  end

  // Serial capture and waveform timing for instance b (LSB-first, 3-cycle half periods).
  logic [15:0] b_word = '0;
  int          b_bits = 0, b_run = 0, b_stab = 0;
  int          b_hi_min = 99, b_hi_max = 0, b_lo_min = 99, b_lo_max = 0, b_min_stab = 99, b_glitch = 0;
  logic        b_psclk = 1'b0, b_pdata = 1'b0, b_clr = 1'b0, b_clr_seen = 1'b0;
  always @(negedge clk) begin
    if (b_clr != b_clr_seen) begin
      b_clr_seen = b_clr;
      b_bits = 0; b_hi_min = 99; b_hi_max = 0; b_lo_min = 99; b_lo_max = 0;
      b_min_stab = 99; b_glitch = 0;
    end
    if (sclk_b && b_psclk && (data_b !== b_pdata)) b_glitch++;
    if (data_b === b_pdata) b_stab++; else b_stab = 0;
    if (sclk_b && !b_psclk) begin
      b_word = {data_b, b_word[15:1]};
      b_bits++;
      if (b_stab < b_min_stab) b_min_stab = b_stab;
      if (b_bits > 1) begin
        if (b_run < b_lo_min) b_lo_min = b_run;
        if (b_run > b_lo_max) b_lo_max = b_run;
      end
      b_run = 0;
    end else if (!sclk_b && b_psclk) begin
      if (b_run < b_hi_min) b_hi_min = b_run;
      if (b_run > b_hi_max) b_hi_max = b_run;
      b_run = 0;
    end
    b_run++;
    b_psclk = sclk_b;
    b_pdata = data_b;
  end

  // Follows one programming cycle: busy cycles before strobe, strobe width, strobe-fall to lock.
  task automatic run_prog(input bit w, output int sh, output int st, output int se);
    int g;
    sh = 0; st = 0; se = 0; g = 0;
    while (!(w ? strobe_b : strobe_a) && g < 3000) begin
      if (w ? busy_b : busy_a) sh++;
      g++;
      step();
    end
    chk_val("strobe_seen", w ? strobe_b : strobe_a, 1);
    while ((w ? strobe_b : strobe_a) && st < 100) begin
      st++;
      step();
    end
    while (!(w ? locked_b : locked_a) && se < 3000) begin
      se++;
      step();
    end
    chk_val("locked_seen", w ? locked_b : locked_a, 1);
  endtask

  int sh, st, se, viol, base_bits, base_stb, g;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    cfg_a = 24'h000000; cfg_b = 16'h0000;
    step(); step();

    chk_val("rst_sclk_a", sclk_a, 0);
    chk_val("rst_data_a", data_a, 0);
    chk_val("rst_strobe_a", strobe_a, 0);
    chk_val("rst_busy_a", busy_a, 0);
    chk_val("rst_locked_a", locked_a, 0);
    chk_val("rst_done_a", done_a, 0);
    chk_val("rst_ready_a", ready_a, 0);
    chk_val("rst_ready_b", ready_b, 0);
    chk_val("iclk_a", iclk_a, clk);

    // Request-driven instance sits idle without a request.
    rst_b = 1'b1;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (sclk_b || strobe_b || busy_b || locked_b) viol++;
    end
    chk_val("idle_activity_b", viol, 0);
    chk_val("idle_ready_b", ready_b, 1);
    chk_val("idle_locked_b", locked_b, 0);
    chk_val("idle_busy_b", busy_b, 0);

    // LSB-first, 3-cycle sclk halves, 16-bit word.
    b_clr = ~b_clr;
    step();
    cfg_b = 16'h8001; valid_b = 1'b1;
    step();
    valid_b = 1'b0; cfg_b = 16'hFFFF;
    chk_val("accept_busy_b", busy_b, 1);
    run_prog(1'b1, sh, st, se);
    chk_val("shift_len_b", sh, 96);
    chk_val("strobe_len_b", st, 2);
    chk_val("settle_b", se, 10);
    chk_val("word_8001_b", b_word, 16'h8001);
    chk_val("bits_b", b_bits, 16);
    chk_val("sclk_hi_min_b", b_hi_min, 3);
    chk_val("sclk_hi_max_b", b_hi_max, 3);
    chk_val("sclk_lo_min_b", b_lo_min, 3);
    chk_val("sclk_lo_max_b", b_lo_max, 3);
    chk_val("setup_ge3_b", (b_min_stab >= 3), 1);
    chk_val("data_hold_b", b_glitch, 0);
    chk_val("done_b", done_b, 1);

    // Asymmetric word exposes bit order.
    b_clr = ~b_clr;
    cfg_b = 16'h0003; valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    run_prog(1'b1, sh, st, se);
    chk_val("word_0003_b", b_word, 16'h0003);
    chk_val("bits_0003_b", b_bits, 16);

    // Auto-start of DEFAULT_CFG on instance a.
    base_bits = a_bits; base_stb = a_stb;
    rst_a = 1'b1;
    run_prog(1'b0, sh, st, se);
    chk_val("shift_len_a", sh, 48);
    chk_val("strobe_len_a", st, 2);
    chk_val("settle_a", se, 20);
    chk_val("word_default_a", a_word, 24'h36A7EB);
    chk_val("bits_default_a", a_bits - base_bits, 24);
    chk_val("strobes_default_a", a_stb - base_stb, 1);
    chk_val("done_rise_a", done_a, 1);
    chk_val("ready_locked_a", ready_a, 1);
    chk_val("busy_locked_a", busy_a, 0);
    step();
    chk_val("done_pulse_a", done_a, 0);
    chk_val("locked_hold_a", locked_a, 1);

    // Reprogram from LOCKED.
    base_bits = a_bits;
    cfg_a = 24'h123456; valid_a = 1'b1;
    step();
    valid_a = 1'b0; cfg_a = 24'h000000;
    chk_val("reprog_locked_drop_a", locked_a, 0);
    chk_val("reprog_busy_a", busy_a, 1);
    chk_val("reprog_ready_a", ready_a, 0);
    run_prog(1'b0, sh, st, se);
    chk_val("busy_total_a", sh + st + se, 70);
    chk_val("word_123456_a", a_word, 24'h123456);
    chk_val("bits_123456_a", a_bits - base_bits, 24);

    // Request held during SHIFT is only taken once LOCKED; later data edits are ignored.
    base_bits = a_bits;
    cfg_a = 24'h5A5A5A; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    repeat (5) step();
    cfg_a = 24'hABCDEF; valid_a = 1'b1;
    run_prog(1'b0, sh, st, se);
    chk_val("word_5a_a", a_word, 24'h5A5A5A);
    chk_val("bits_5a_a", a_bits - base_bits, 24);
    base_bits = a_bits; base_stb = a_stb;
    step();
    valid_a = 1'b0;
    chk_val("held_accept_a", busy_a, 1);
    repeat (10) step();
    cfg_a = 24'h111111;
    run_prog(1'b0, sh, st, se);
    chk_val("word_abcdef_a", a_word, 24'hABCDEF);
    chk_val("bits_abcdef_a", a_bits - base_bits, 24);
    chk_val("strobes_abcdef_a", a_stb - base_stb, 1);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy_a || !locked_a) viol++;
    end
    chk_val("single_reprog_a", viol, 0);

    // Reset in the middle of a shift.
    cfg_a = 24'hFFFFFF; valid_a = 1'b1;
    base_bits = a_bits;
    step();
    valid_a = 1'b0;
    g = 0;
    while ((a_bits - base_bits) < 10 && g < 200) begin
      step();
      g++;
    end
    chk_val("reached_bit10_a", a_bits - base_bits, 10);
    base_stb = a_stb;
    rst_a = 1'b0;
    #1;
    chk_val("midrst_sclk_a", sclk_a, 0);
    chk_val("midrst_data_a", data_a, 0);
    chk_val("midrst_strobe_a", strobe_a, 0);
    chk_val("midrst_locked_a", locked_a, 0);
    chk_val("midrst_busy_a", busy_a, 0);
    repeat (5) step();
    chk_val("midrst_no_strobe_a", a_stb - base_stb, 0);
    base_bits = a_bits;
    rst_a = 1'b1;
    run_prog(1'b0, sh, st, se);
    chk_val("post_rst_shift_a", sh, 48);
    chk_val("post_rst_word_a", a_word, 24'h36A7EB);
    chk_val("post_rst_bits_a", a_bits - base_bits, 24);
    chk_val("post_rst_strobes_a", a_stb - base_stb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
